jump_resolver_n: RTL and testbench

//  Front-end jump resolver for an N-wide fetch group, between fetch and decode.

---
 rtl/jump_resolver_n_if.sv | 38 +++
 rtl/jump_resolver_n.sv | 154 +++++++++++++++
 tb/tb_jump_resolver_n.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jump_resolver_n_if.sv
// Purpose : bundle of fetch, base-register handshake and decode-side signals
//           for jump_resolver_n.
// Ports   : slave  - the resolver (consumes fetch/base inputs, drives redirect,
//                    stall, lanes, base request and error)
//           master - the fetch/regfile/decode side driving the resolver
interface jump_resolver_n_if #(
    parameter int FETCH_W = 4,
    parameter int IW      = 16,
    parameter int AW      = 16,
    parameter int RS_W    = 4
);
    logic                    flush;
    logic                    fetch_valid;
    logic [AW-1:0]           fetch_pc;
    logic [FETCH_W*IW-1:0]   fetch_instr;
    logic                    base_req;
    logic [RS_W-1:0]         base_rs;
    logic                    base_valid;
    logic [AW-1:0]           base_data;
    logic                    redirect_valid;
    logic [AW-1:0]           redirect_pc;
    logic                    stall;
    logic [FETCH_W*IW-1:0]   instr_out;
    logic [FETCH_W-1:0]      lane_valid;
    logic                    err_timeout;

    modport slave (
        input  flush, fetch_valid, fetch_pc, fetch_instr, base_valid, base_data,
        output base_req, base_rs, redirect_valid, redirect_pc, stall,
               instr_out, lane_valid, err_timeout
    );

    modport master (
        output flush, fetch_valid, fetch_pc, fetch_instr, base_valid, base_data,
        input  base_req, base_rs, redirect_valid, redirect_pc, stall,
               instr_out, lane_valid, err_timeout
    );
endinterface

// File: rtl/jump_resolver_n.sv
// Purpose : front-end jump resolver for a FETCH_W-wide fetch group.
//           Immediate jumps redirect in the same cycle; register jumps stall,
//           fetch the base register over base_req/base_valid, then redirect
//           to base+offset one cycle after base_valid. A watchdog bounds the
//           wait and sets a sticky err_timeout. flush overrides everything.
// Ports   : clk, rst_n (async, active low)
//           bus (jump_resolver_n_if.slave): fetch group in, base handshake,
//           redirect/stall out, per-lane instr/valid to decode, err_timeout.
module jump_resolver_n #(
    parameter int FETCH_W = 4,
    parameter int IW      = 16,
    parameter int AW      = 16,
    parameter int IMM_W   = 10,
    parameter int ROFF_W  = 6,
    parameter int RS_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    jump_resolver_n_if.slave bus
);
    localparam int KW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    logic [1:0]         r_state;
    logic [RS_W-1:0]    r_rs;
    logic [AW-1:0]      r_off;
    logic [AW-1:0]      r_base;
    logic [CW-1:0]      r_wd;
    logic               r_err;

    logic [FETCH_W-1:0] w_is_jmp;
    logic [FETCH_W-1:0] w_keep;
    logic               w_hit;
    logic [KW-1:0]      w_k;
    logic               w_is_reg;
    logic [IMM_W-1:0]   w_imm;
    logic [ROFF_W-1:0]  w_roff;
    logic [RS_W-1:0]    w_rs;
    logic [AW-1:0]      w_imm_tgt;
    logic               w_expire;

    // Per-lane decode, keep mask and squash of instructions to decode.
    for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
        assign w_is_jmp[g] = bus.fetch_valid && (bus.fetch_instr[g*IW+12 +: 4] == 4'hF);
        assign w_keep[g]   = !w_hit || (KW'(g) <= w_k);
        assign bus.instr_out[g*IW +: IW] = bus.lane_valid[g] ? bus.fetch_instr[g*IW +: IW] : '0;
    end

    // Oldest jump lane wins: scan from youngest down so the lowest index sticks.
    always_comb begin
        w_hit = 1'b0;
        w_k   = '0;
        for (int k = FETCH_W - 1; k >= 0; k--) begin
            if (w_is_jmp[k]) begin
                w_hit = 1'b1;
                w_k   = KW'(k);
            end
        end
    end

    assign w_is_reg  = w_hit && bus.fetch_instr[w_k*IW];
    assign w_imm     = bus.fetch_instr[w_k*IW+2 +: IMM_W];
    assign w_roff    = bus.fetch_instr[w_k*IW+2 +: ROFF_W];
    assign w_rs      = bus.fetch_instr[w_k*IW+12-RS_W +: RS_W];
    assign w_imm_tgt = bus.fetch_pc + AW'(w_k) + AW'(1)
                     + {{(AW-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    // Fires in the TIMEOUT-th WAIT cycle (counter starts at 0 on entry).
    assign w_expire  = (TIMEOUT != 0) && (r_wd == CW'(TIMEOUT - 1));

    always_comb begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;
        bus.lane_valid     = '0;
        bus.base_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.fetch_valid) begin
                    bus.lane_valid = w_keep;
                    if (w_is_reg) begin
                        bus.stall = 1'b1;
                    end else if (w_hit) begin
                        bus.redirect_valid = 1'b1;
                        bus.redirect_pc    = w_imm_tgt;
                    end
                end
            end
            S_WAIT: begin
                bus.stall    = 1'b1;
                bus.base_req = 1'b1;
            end
            S_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_base + r_off;
            end
            default: ;
        endcase
        if (bus.flush) begin
            bus.redirect_valid = 1'b0;
            bus.redirect_pc    = '0;
            bus.stall          = 1'b0;
            bus.lane_valid     = '0;
            bus.base_req       = 1'b0;
        end
    end

    assign bus.base_rs     = r_rs;
    assign bus.err_timeout = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rs    <= '0;
            r_off   <= '0;
            r_base  <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_wd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_reg) begin
                        r_rs    <= w_rs;
                        r_off   <= {{(AW-ROFF_W){w_roff[ROFF_W-1]}}, w_roff};
                        r_wd    <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // base_valid takes precedence over a same-cycle expiry
                    if (bus.base_valid) begin
                        r_base  <= bus.base_data;
                        r_state <= S_REDIR;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd    <= r_wd + 1'b1;
                    end
                end
                S_REDIR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jump_resolver_n.sv
module tb_jump_resolver_n;
    localparam int FW = 4;
    localparam int IW = 16;
    localparam int AW = 16;
    localparam int RS_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jump_resolver_n_if #(.FETCH_W(FW), .IW(IW), .AW(AW), .RS_W(RS_W)) bus ();

    jump_resolver_n #(
        .FETCH_W(FW), .IW(IW), .AW(AW), .IMM_W(10), .ROFF_W(6), .RS_W(RS_W), .TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;

    function automatic logic [FW*IW-1:0] grp(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.flush = 1'b0; bus.fetch_valid = 1'b0; bus.fetch_pc = '0;
        bus.fetch_instr = '0; bus.base_valid = 1'b0; bus.base_data = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc, bus.stall, bus.lane_valid, bus.instr_out,
             bus.base_req, bus.base_rs, bus.err_timeout} !== '0) begin
            errs++; $display("FAIL reset_outputs: rv=%b pc=%h st=%b lv=%b req=%b rs=%h err=%b want all 0",
                bus.redirect_valid, bus.redirect_pc, bus.stall, bus.lane_valid, bus.base_req, bus.base_rs, bus.err_timeout);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_jump();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0040;
        bus.fetch_instr = grp(16'h1111, 16'h2222, 16'hE333, 16'h0444);
        #2;
        checks++;
        if (bus.lane_valid !== 4'b1111 || bus.instr_out !== 64'h0444_E333_2222_1111 ||
            bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0) begin
            errs++; $display("FAIL no_jump: lv=%b io=%h rv=%b st=%b want 1111 0444e33322221111 0 0",
                bus.lane_valid, bus.instr_out, bus.redirect_valid, bus.stall);
        end
        tick(); quiet();
    endtask

    task automatic test_imm_lane2();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0100;
        bus.fetch_instr = grp(16'h1111, 16'h2222, 16'hF014, 16'h4444);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h0108) begin
            errs++; $display("FAIL imm_lane2_pc: rv=%b pc=%h want 1 0108", bus.redirect_valid, bus.redirect_pc);
        end
        checks++;
        if (bus.lane_valid !== 4'b0111 || bus.instr_out !== 64'h0000_F014_2222_1111 || bus.stall !== 1'b0) begin
            errs++; $display("FAIL imm_lane2_lanes: lv=%b io=%h st=%b want 0111 0000f01422221111 0",
                bus.lane_valid, bus.instr_out, bus.stall);
        end
        tick(); quiet();
    endtask

    task automatic test_imm_wrap();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0000;
        bus.fetch_instr = grp(16'hFFF0, 16'h2222, 16'h3333, 16'h4444);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'hFFFD || bus.lane_valid !== 4'b0001) begin
            errs++; $display("FAIL imm_wrap: rv=%b pc=%h lv=%b want 1 fffd 0001",
                bus.redirect_valid, bus.redirect_pc, bus.lane_valid);
        end
        tick(); quiet();
    endtask

    task automatic test_back_to_back();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0200;
        bus.fetch_instr = grp(16'h1111, 16'h2222, 16'h3333, 16'hF040);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h0214 || bus.lane_valid !== 4'b1111) begin
            errs++; $display("FAIL b2b_first: rv=%b pc=%h lv=%b want 1 0214 1111",
                bus.redirect_valid, bus.redirect_pc, bus.lane_valid);
        end
        tick();
        bus.fetch_pc = 16'h0300;
        bus.fetch_instr = grp(16'h1111, 16'hFFFC, 16'hF040, 16'h4444);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h0301 || bus.lane_valid !== 4'b0011) begin
            errs++; $display("FAIL b2b_second: rv=%b pc=%h lv=%b want 1 0301 0011",
                bus.redirect_valid, bus.redirect_pc, bus.lane_valid);
        end
        tick(); quiet();
    endtask

    task automatic test_reg_jump();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0400;
        bus.fetch_instr = grp(16'h1111, 16'hF30D, 16'h3333, 16'h4444);
        #2;
        checks++;
        if (bus.lane_valid !== 4'b0011 || bus.stall !== 1'b1 || bus.redirect_valid !== 1'b0 ||
            bus.instr_out !== 64'h0000_0000_F30D_1111) begin
            errs++; $display("FAIL reg_issue: lv=%b st=%b rv=%b io=%h want 0011 1 0 00000000f30d1111",
                bus.lane_valid, bus.stall, bus.redirect_valid, bus.instr_out);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.base_valid = (i == 2); bus.base_data = 16'h2000;
            #2;
            checks++;
            if (bus.base_req !== 1'b1 || bus.base_rs !== 4'd3 || bus.stall !== 1'b1 ||
                bus.lane_valid !== 4'b0000 || bus.redirect_valid !== 1'b0) begin
                errs++; $display("FAIL reg_wait%0d: req=%b rs=%0d st=%b lv=%b rv=%b want 1 3 1 0000 0",
                    i, bus.base_req, bus.base_rs, bus.stall, bus.lane_valid, bus.redirect_valid);
            end
            tick();
        end
        bus.base_valid = 1'b0;
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h2003 || bus.stall !== 1'b0 ||
            bus.lane_valid !== 4'b0000 || bus.base_req !== 1'b0) begin
            errs++; $display("FAIL reg_redirect: rv=%b pc=%h st=%b lv=%b req=%b want 1 2003 0 0000 0",
                bus.redirect_valid, bus.redirect_pc, bus.stall, bus.lane_valid, bus.base_req);
        end
        bus.fetch_valid = 1'b0;
        tick();
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0 || bus.base_req !== 1'b0) begin
            errs++; $display("FAIL reg_back_idle: rv=%b st=%b req=%b want 0 0 0",
                bus.redirect_valid, bus.stall, bus.base_req);
        end
        quiet();
    endtask

    task automatic test_reg_priority();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0500;
        bus.fetch_instr = grp(16'hF5F9, 16'h2222, 16'h3333, 16'hF014);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.lane_valid !== 4'b0001 || bus.stall !== 1'b1) begin
            errs++; $display("FAIL prio_issue: rv=%b lv=%b st=%b want 0 0001 1",
                bus.redirect_valid, bus.lane_valid, bus.stall);
        end
        tick();
        bus.fetch_valid = 1'b0; bus.base_valid = 1'b1; bus.base_data = 16'h1000;
        #2;
        checks++;
        if (bus.base_rs !== 4'd5 || bus.base_req !== 1'b1) begin
            errs++; $display("FAIL prio_rs: rs=%0d req=%b want 5 1", bus.base_rs, bus.base_req);
        end
        tick(); bus.base_valid = 1'b0;
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h0FFE) begin
            errs++; $display("FAIL prio_redirect: rv=%b pc=%h want 1 0ffe", bus.redirect_valid, bus.redirect_pc);
        end
        tick(); quiet();
    endtask

    task automatic test_flush();
        bus.fetch_valid = 1'b1; bus.flush = 1'b1; bus.fetch_pc = 16'h0100;
        bus.fetch_instr = grp(16'h1111, 16'h2222, 16'hF014, 16'h4444);
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.lane_valid !== 4'b0000) begin
            errs++; $display("FAIL flush_idle: rv=%b lv=%b want 0 0000", bus.redirect_valid, bus.lane_valid);
        end
        tick(); quiet();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = grp(16'hF30D, 16'h2222, 16'h3333, 16'h4444);
        tick(); quiet();
        tick();
        bus.flush = 1'b1; bus.base_valid = 1'b1; bus.base_data = 16'h7000;
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.base_req !== 1'b0 || bus.stall !== 1'b0) begin
            errs++; $display("FAIL flush_wait: rv=%b req=%b st=%b want 0 0 0",
                bus.redirect_valid, bus.base_req, bus.stall);
        end
        tick(); quiet();
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0 || bus.base_req !== 1'b0) begin
                errs++; $display("FAIL flush_after%0d: rv=%b st=%b req=%b want 0 0 0",
                    i, bus.redirect_valid, bus.stall, bus.base_req);
            end
            tick();
        end
    endtask

    task automatic test_expiry_race();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = grp(16'hF201, 16'h2222, 16'h3333, 16'h4444);
        tick(); quiet();
        for (int i = 0; i < 7; i++) tick();
        bus.base_valid = 1'b1; bus.base_data = 16'h3456;
        tick(); quiet();
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h3456 || bus.err_timeout !== 1'b0) begin
            errs++; $display("FAIL expiry_race: rv=%b pc=%h err=%b want 1 3456 0",
                bus.redirect_valid, bus.redirect_pc, bus.err_timeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = grp(16'hF201, 16'h2222, 16'h3333, 16'h4444);
        tick(); quiet();
        for (int i = 0; i < 7; i++) tick();
        #2;
        checks++;
        if (bus.base_req !== 1'b1 || bus.err_timeout !== 1'b0) begin
            errs++; $display("FAIL timeout_cycle8: req=%b err=%b want 1 0", bus.base_req, bus.err_timeout);
        end
        tick();
        #2;
        checks++;
        if (bus.err_timeout !== 1'b1 || bus.base_req !== 1'b0 || bus.stall !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errs++; $display("FAIL timeout_expired: err=%b req=%b st=%b rv=%b want 1 0 0 0",
                bus.err_timeout, bus.base_req, bus.stall, bus.redirect_valid);
        end
        for (int i = 0; i < 3; i++) tick();
        bus.fetch_valid = 1'b1; bus.fetch_pc = 16'h0100;
        bus.fetch_instr = grp(16'h1111, 16'h2222, 16'hF014, 16'h4444);
        #2;
        checks++;
        if (bus.err_timeout !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 16'h0108) begin
            errs++; $display("FAIL timeout_sticky: err=%b rv=%b pc=%h want 1 1 0108",
                bus.err_timeout, bus.redirect_valid, bus.redirect_pc);
        end
        tick(); quiet();
    endtask

    task automatic test_async_reset_mid_wait();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = grp(16'hF30D, 16'h2222, 16'h3333, 16'h4444);
        tick(); quiet();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.base_req, bus.stall, bus.redirect_valid, bus.lane_valid, bus.err_timeout, bus.base_rs} !== '0) begin
            errs++; $display("FAIL async_reset: req=%b st=%b rv=%b lv=%b err=%b rs=%0d want all 0",
                bus.base_req, bus.stall, bus.redirect_valid, bus.lane_valid, bus.err_timeout, bus.base_rs);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        bus.base_valid = 1'b1; bus.base_data = 16'h1234;
        tick(); bus.base_valid = 1'b0;
        #2;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.base_req !== 1'b0 || bus.stall !== 1'b0) begin
            errs++; $display("FAIL idle_base_valid: rv=%b req=%b st=%b want 0 0 0",
                bus.redirect_valid, bus.base_req, bus.stall);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_no_jump();
        test_imm_lane2();
        test_imm_wrap();
        test_back_to_back();
        test_reg_jump();
        test_reg_priority();
        test_flush();
        test_expiry_race();
        test_timeout();
        test_async_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
